tt_gpio_cfg_loader: RTL and testbench

Runtime pad-configuration receiver for the openframe top level. It accepts a byte-stream command protocol over a valid/ready handshake and holds one shadow and one active configuration register per GPIO pad. The active registers drive the per-pad control vectors (inp_dis, ib_mode_sel, vtrip_sel, slow_sel, holdover, analog_en/sel/pol, dm[2:0]). These outputs replace the static tie-offs in the wrapper.

---
 rtl/tt_gpio_cfg_pkg.sv | 37 +++
 rtl/tt_gpio_cfg_pad.sv | 49 ++++
 rtl/tt_gpio_cfg_loader.sv | 151 +++++++++++++++
 tb/tb_tt_gpio_cfg_loader.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_gpio_cfg_pkg.sv
// Shared constants, field positions and FSM state type for the GPIO pad-config loader.
package tt_gpio_cfg_pkg;

    // Width of one pad configuration word.
    localparam int unsigned CFG_W = 11;

    // Command opcodes, carried in bits [7:6] of the command byte.
    localparam logic [1:0] OP_WRITE    = 2'b00;
    localparam logic [1:0] OP_BCAST    = 2'b01;
    localparam logic [1:0] OP_APPLY    = 2'b10;
    localparam logic [1:0] OP_DEFAULTS = 2'b11;

    // Bit positions inside a configuration word.
    localparam int unsigned CFG_DM_LSB      = 0;
    localparam int unsigned CFG_INP_DIS     = 3;
    localparam int unsigned CFG_IB_MODE_SEL = 4;
    localparam int unsigned CFG_VTRIP_SEL   = 5;
    localparam int unsigned CFG_SLOW_SEL    = 6;
    localparam int unsigned CFG_HOLDOVER    = 7;
    localparam int unsigned CFG_ANALOG_EN   = 8;
    localparam int unsigned CFG_ANALOG_SEL  = 9;
    localparam int unsigned CFG_ANALOG_POL  = 10;

    typedef enum logic [1:0] {
        IDLE,
        DATA_HI,
        DATA_LO,
        COMMIT
    } state_e;

    // Build a config word from the two data bytes; high-byte bits [7:3] are reserved.
    function automatic logic [CFG_W-1:0] cfg_from_bytes(input logic [2:0] hi,
                                                        input logic [7:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/tt_gpio_cfg_pad.sv
// One pad's shadow/active configuration register pair.
module tt_gpio_cfg_pad
    import tt_gpio_cfg_pkg::*;
#(
    parameter logic [CFG_W-1:0] DEFAULT_CFG = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [CFG_W-1:0] wdata_i,
    input  logic             apply_i,
    input  logic             defaults_i,
    output logic [CFG_W-1:0] active_o
);

    logic [CFG_W-1:0] shadow_q, shadow_d;
    logic [CFG_W-1:0] active_q, active_d;

    // Next-state: defaults override everything, apply copies shadow into active.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        if (defaults_i) begin
            shadow_d = DEFAULT_CFG;
            active_d = DEFAULT_CFG;
        end else begin
            if (wr_en_i) begin
                shadow_d = wdata_i;
            end
            if (apply_i) begin
                active_d = shadow_q;
            end
        end
    end

    // Register pair with synchronous reset to the default word.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= DEFAULT_CFG;
            active_q <= DEFAULT_CFG;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign active_o = active_q;

endmodule

// File: rtl/tt_gpio_cfg_loader.sv
// Byte-stream pad configuration receiver: command FSM, data assembly, index decode
// and fan-out of the active words onto per-field pad control vectors.
module tt_gpio_cfg_loader
    import tt_gpio_cfg_pkg::*;
#(
    parameter int unsigned      N_PADS      = 44,
    parameter logic [CFG_W-1:0] DEFAULT_CFG = 11'h000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              busy,
    output logic              err,
    output logic [N_PADS-1:0] gpio_inp_dis,
    output logic [N_PADS-1:0] gpio_ib_mode_sel,
    output logic [N_PADS-1:0] gpio_vtrip_sel,
    output logic [N_PADS-1:0] gpio_slow_sel,
    output logic [N_PADS-1:0] gpio_holdover,
    output logic [N_PADS-1:0] gpio_analog_en,
    output logic [N_PADS-1:0] gpio_analog_sel,
    output logic [N_PADS-1:0] gpio_analog_pol,
    output logic [N_PADS-1:0] gpio_dm2,
    output logic [N_PADS-1:0] gpio_dm1,
    output logic [N_PADS-1:0] gpio_dm0
);

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [5:0]  idx_q, idx_d;
    logic [2:0]  hi_q, hi_d;
    logic [7:0]  lo_q, lo_d;
    logic        err_q, err_d;

    logic             accept;
    logic             commit;
    logic             idx_oor;
    logic             wr_one, wr_all, apply, dflt;
    logic [CFG_W-1:0] wdata;
    logic [CFG_W-1:0] active_w [N_PADS];

    assign in_ready = (state_q != COMMIT);
    assign busy     = (state_q != IDLE);
    assign err      = err_q;
    assign accept   = in_valid & in_ready;
    assign commit   = (state_q == COMMIT);
    // Widen by one bit so N_PADS = 64 compares correctly.
    assign idx_oor  = ({1'b0, idx_q} >= 7'(N_PADS));

    // Frame sequencing, byte capture and sticky error update.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        idx_d   = idx_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d  = in_data[7:6];
                    idx_d = in_data[5:0];
                    if (in_data[7:6] == OP_WRITE || in_data[7:6] == OP_BCAST) begin
                        state_d = DATA_HI;
                    end else begin
                        state_d = COMMIT;
                    end
                end
            end
            DATA_HI: begin
                if (accept) begin
                    hi_d    = in_data[2:0];
                    state_d = DATA_LO;
                end
            end
            DATA_LO: begin
                if (accept) begin
                    lo_d    = in_data;
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                state_d = IDLE;
                if (op_q == OP_WRITE && idx_oor) begin
                    err_d = 1'b1;
                end
                if (op_q == OP_DEFAULTS) begin
                    err_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers; reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_WRITE;
            idx_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            err_q   <= err_d;
        end
    end

    assign wdata  = cfg_from_bytes(hi_q, lo_q);
    assign wr_one = commit & (op_q == OP_WRITE);
    assign wr_all = commit & (op_q == OP_BCAST);
    assign apply  = commit & (op_q == OP_APPLY);
    assign dflt   = commit & (op_q == OP_DEFAULTS);

    for (genvar i = 0; i < N_PADS; i++) begin : g_pad
        logic wr_en;
        // Out-of-range indices never match any instantiated pad.
        assign wr_en = wr_all | (wr_one & (idx_q == 6'(i)));

        tt_gpio_cfg_pad #(
            .DEFAULT_CFG(DEFAULT_CFG)
        ) u_pad (
            .clk       (clk),
            .rst       (rst),
            .wr_en_i   (wr_en),
            .wdata_i   (wdata),
            .apply_i   (apply),
            .defaults_i(dflt),
            .active_o  (active_w[i])
        );

        assign gpio_dm0[i]         = active_w[i][CFG_DM_LSB];
        assign gpio_dm1[i]         = active_w[i][CFG_DM_LSB+1];
        assign gpio_dm2[i]         = active_w[i][CFG_DM_LSB+2];
        assign gpio_inp_dis[i]     = active_w[i][CFG_INP_DIS];
        assign gpio_ib_mode_sel[i] = active_w[i][CFG_IB_MODE_SEL];
        assign gpio_vtrip_sel[i]   = active_w[i][CFG_VTRIP_SEL];
        assign gpio_slow_sel[i]    = active_w[i][CFG_SLOW_SEL];
        assign gpio_holdover[i]    = active_w[i][CFG_HOLDOVER];
        assign gpio_analog_en[i]   = active_w[i][CFG_ANALOG_EN];
        assign gpio_analog_sel[i]  = active_w[i][CFG_ANALOG_SEL];
        assign gpio_analog_pol[i]  = active_w[i][CFG_ANALOG_POL];
    end

endmodule

// File: tb/tb_tt_gpio_cfg_loader.sv
// Self-checking bench for tt_gpio_cfg_loader with a reference model and scoreboard queue.
module tb_tt_gpio_cfg_loader;

    localparam int N  = 44;
    localparam int VW = 11 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready, busy, err;
    logic [N-1:0] inp_dis, ib_mode, vtrip, slow, holdover, an_en, an_sel, an_pol;
    logic [N-1:0] dm2, dm1, dm0;
    logic [VW-1:0] obs;

    typedef struct packed {
        logic [VW-1:0] vec;
        logic          err;
    } exp_t;

    exp_t      sb[$];
    exp_t      e;
    logic [10:0] m_sh  [N];
    logic [10:0] m_act [N];
    logic        m_err;
    int          checks = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    tt_gpio_cfg_loader #(
        .N_PADS     (N),
        .DEFAULT_CFG(11'h000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .busy            (busy),
        .err             (err),
        .gpio_inp_dis    (inp_dis),
        .gpio_ib_mode_sel(ib_mode),
        .gpio_vtrip_sel  (vtrip),
        .gpio_slow_sel   (slow),
        .gpio_holdover   (holdover),
        .gpio_analog_en  (an_en),
        .gpio_analog_sel (an_sel),
        .gpio_analog_pol (an_pol),
        .gpio_dm2        (dm2),
        .gpio_dm1        (dm1),
        .gpio_dm0        (dm0)
    );

    // Field k of pad i lands at bit k*N+i, dm0 lowest.
    assign obs = {an_pol, an_sel, an_en, holdover, slow, vtrip, ib_mode, inp_dis, dm2, dm1, dm0};

    function automatic logic [VW-1:0] model_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < N; i++) begin
            for (int b = 0; b < 11; b++) begin
                v[b*N+i] = m_act[i][b];
            end
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_sh[i]  = 11'h000;
            m_act[i] = 11'h000;
        end
        m_err = 1'b0;
    endtask

    task automatic model_write(input int idx, input logic [7:0] hi, input logic [7:0] lo);
        if (idx < N) m_sh[idx] = {hi[2:0], lo};
        else m_err = 1'b1;
    endtask

    task automatic model_bcast(input logic [7:0] hi, input logic [7:0] lo);
        for (int i = 0; i < N; i++) m_sh[i] = {hi[2:0], lo};
    endtask

    task automatic model_apply();
        for (int i = 0; i < N; i++) m_act[i] = m_sh[i];
    endtask

    task automatic push_exp();
        exp_t x;
        x.vec = model_vec();
        x.err = m_err;
        sb.push_back(x);
    endtask

    // Hand one byte over the handshake; returns #1 after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int  n    = 0;
        bit  done = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        while (!done && n < 16) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            $display("FAIL send_timeout byte=%h in_ready stayed %b", b, in_ready);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        checks++;
        if (obs !== model_vec()) $display("FAIL rst_vec got=%h exp=%h", obs, model_vec());
        else passed++;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL rst_ready got=%b exp=1", in_ready);
        else passed++;
        checks++;
        if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy);
        else passed++;
        checks++;
        if (err !== 1'b0) $display("FAIL rst_err got=%b exp=0", err);
        else passed++;
    endtask

    task automatic test_write_apply();
        send_byte(8'h05); send_byte(8'h00); send_byte(8'h06);
        model_write(5, 8'h00, 8'h06);
        push_exp();
        step();
        e = sb.pop_front();
        checks++;
        if (obs !== e.vec) $display("FAIL wr_no_touch got=%h exp=%h", obs, e.vec);
        else passed++;
        send_byte(8'h80);
        // In COMMIT: active must not have moved yet.
        checks++;
        if (obs !== model_vec()) $display("FAIL apply_latency got=%h exp=%h", obs, model_vec());
        else passed++;
        model_apply();
        push_exp();
        step();
        e = sb.pop_front();
        checks++;
        if (obs !== e.vec) $display("FAIL apply_vec got=%h exp=%h", obs, e.vec);
        else passed++;
        checks++;
        if ({dm2[5], dm1[5], dm0[5]} !== 3'b110)
            $display("FAIL pad5_dm got=%b exp=110", {dm2[5], dm1[5], dm0[5]});
        else passed++;
    endtask

    task automatic test_bcast();
        send_byte(8'h40); send_byte(8'h07); send_byte(8'hFF);
        model_bcast(8'h07, 8'hFF);
        step();
        send_byte(8'h80);
        model_apply();
        push_exp();
        step();
        e = sb.pop_front();
        checks++;
        if (obs !== e.vec) $display("FAIL bcast_vec got=%h exp=%h", obs, e.vec);
        else passed++;
        checks++;
        if (an_pol !== {N{1'b1}}) $display("FAIL bcast_pol got=%h exp=all ones", an_pol);
        else passed++;
    endtask

    task automatic test_error();
        send_byte(8'hC0);
        model_reset();
        push_exp();
        step();
        e = sb.pop_front();
        checks++;
        if (obs !== e.vec) $display("FAIL dflt_vec got=%h exp=%h", obs, e.vec);
        else passed++;
        // Pad 44 is one past the last pad.
        send_byte(8'h2C); send_byte(8'h00); send_byte(8'h01);
        model_write(44, 8'h00, 8'h01);
        push_exp();
        step();
        e = sb.pop_front();
        checks++;
        if (err !== e.err) $display("FAIL oor_err got=%b exp=%b", err, e.err);
        else passed++;
        send_byte(8'h80);
        model_apply();
        push_exp();
        step();
        e = sb.pop_front();
        checks++;
        if (obs !== e.vec) $display("FAIL oor_no_write got=%h exp=%h", obs, e.vec);
        else passed++;
        // BCAST with index 63 must not disturb err.
        send_byte(8'h7F); send_byte(8'h00); send_byte(8'h00);
        model_bcast(8'h00, 8'h00);
        push_exp();
        step();
        e = sb.pop_front();
        checks++;
        if (err !== e.err) $display("FAIL bcast_err got=%b exp=%b", err, e.err);
        else passed++;
        send_byte(8'hC0);
        model_reset();
        push_exp();
        step();
        e = sb.pop_front();
        checks++;
        if (err !== e.err) $display("FAIL dflt_err_clr got=%b exp=%b", err, e.err);
        else passed++;
    endtask

    task automatic test_last_write_wins();
        send_byte(8'h2B); send_byte(8'h00); send_byte(8'h01);
        model_write(43, 8'h00, 8'h01);
        step();
        send_byte(8'h2B); send_byte(8'h00); send_byte(8'h02);
        model_write(43, 8'h00, 8'h02);
        step();
        send_byte(8'h80);
        model_apply();
        push_exp();
        step();
        e = sb.pop_front();
        checks++;
        if (obs !== e.vec) $display("FAIL last_wins_vec got=%h exp=%h", obs, e.vec);
        else passed++;
        checks++;
        if ({dm1[43], dm0[43]} !== 2'b10)
            $display("FAIL pad43_dm got=%b exp=10", {dm1[43], dm0[43]});
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [6] = '{8'h05, 8'h07, 8'hFF, 8'h06, 8'h00, 8'h01};
        logic [7:0] rdy;
        int         k = 0;
        in_data  = bytes[0];
        in_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            rdy[c] = in_ready;
            @(posedge clk);
            #1;
            if (rdy[c] && k < 6) begin
                k++;
                if (k < 6) in_data = bytes[k];
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        model_write(5, 8'h07, 8'hFF);
        model_write(6, 8'h00, 8'h01);
        checks++;
        if (k !== 6) $display("FAIL b2b_count got=%0d exp=6", k);
        else passed++;
        checks++;
        if (rdy !== 8'h77) $display("FAIL b2b_ready got=%b exp=01110111", rdy);
        else passed++;
        send_byte(8'h80);
        model_apply();
        push_exp();
        step();
        e = sb.pop_front();
        checks++;
        if (obs !== e.vec) $display("FAIL b2b_vec got=%h exp=%h", obs, e.vec);
        else passed++;
    endtask

    task automatic test_reset_midframe();
        send_byte(8'h07); send_byte(8'h07); send_byte(8'hFF);
        model_write(7, 8'h07, 8'hFF);
        step();
        send_byte(8'h03); send_byte(8'h00);
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        checks++;
        if (busy !== 1'b0) $display("FAIL mid_rst_busy got=%b exp=0", busy);
        else passed++;
        // A surviving partial frame would swallow the first 0x80 as data.
        send_byte(8'h80);
        step();
        send_byte(8'h80);
        model_apply();
        push_exp();
        step();
        e = sb.pop_front();
        checks++;
        if (obs !== e.vec) $display("FAIL mid_rst_vec got=%h exp=%h", obs, e.vec);
        else passed++;
        // Reset asserted during an APPLY commit wins over it.
        send_byte(8'h00); send_byte(8'h07); send_byte(8'hFF);
        step();
        send_byte(8'h80);
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        push_exp();
        e = sb.pop_front();
        checks++;
        if (obs !== e.vec) $display("FAIL rst_prio_vec got=%h exp=%h", obs, e.vec);
        else passed++;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_apply();
        test_bcast();
        test_error();
        test_last_write_wins();
        test_back_to_back();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
